// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types for the multi-lane instruction fetch stage
package if_pkg;

  localparam int PC_BITS_DEF    = 32;
  localparam int INSTR_BITS_DEF = 32;
  localparam int LANES_DEF      = 4;
  localparam int QDEPTH_DEF     = 4;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_LOW  = 2'd1,
    PEND_HIGH = 2'd2
  } pend_e;

  typedef struct packed {
    logic [PC_BITS_DEF-1:0]              pc;
    logic [LANES_DEF*INSTR_BITS_DEF-1:0] instr;
    logic [LANES_DEF-1:0]                lane_valid;
    logic [LANES_DEF-1:0]                taken;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_pkt_queue.sv
// rtl/fetch_pkt_queue.sv - circular packet FIFO with synchronous clear
module fetch_pkt_queue #(
  parameter int  QDEPTH = 4,
  parameter type T      = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(QDEPTH);

  T               mem [QDEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(QDEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/if_multi_fetch.sv
// rtl/if_multi_fetch.sv - multi-lane fetch: lane trim, PC mux, redirect hold FSM, packet queue
module if_multi_fetch
  import if_pkg::*;
#(
  parameter int PC_BITS    = PC_BITS_DEF,
  parameter int INSTR_BITS = INSTR_BITS_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int QDEPTH     = QDEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [PC_BITS-1:0]            fetch_pc,
  output logic                          fetch_req,
  input  logic                          cache_hit,
  input  logic [$clog2(LANES):0]        cache_cnt,
  input  logic [LANES*INSTR_BITS-1:0]   fetched_data,
  input  logic [LANES-1:0]              pred_taken,
  input  logic [PC_BITS-1:0]            pred_target,
  input  logic                          flush_valid,
  input  logic [PC_BITS-1:0]            flush_pc,
  input  logic                          mispred_valid,
  input  logic [PC_BITS-1:0]            mispred_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PC_BITS-1:0]            out_pc,
  output logic [LANES*INSTR_BITS-1:0]   out_instr,
  output logic [LANES-1:0]              out_lane_valid,
  output logic [LANES-1:0]              out_taken,
  output logic [31:0]                   perf_redirects
);

  localparam int CW = $clog2(LANES) + 1;

  typedef struct packed {
    logic [PC_BITS-1:0]          pc;
    logic [LANES*INSTR_BITS-1:0] instr;
    logic [LANES-1:0]            lane_valid;
    logic [LANES-1:0]            taken;
  } pkt_t;

  pend_e              pend, pend_nxt;
  logic [PC_BITS-1:0] saved_pc, saved_nxt, pc_nxt;
  logic               redirect, accept, pop, q_full, q_empty, count_inc;
  logic               found;
  logic [CW-1:0]      t_idx, keep;
  logic [LANES-1:0]   tk_in, mask;
  logic [PC_BITS-1:0] seq_pc, redir_pc;
  pkt_t               push_pkt, head_pkt;

  // Lowest taken lane among the valid ones ends the packet.
  always_comb begin
    found = 1'b0;
    t_idx = '0;
    for (int i = 0; i < LANES; i++) tk_in[i] = pred_taken[i] && (CW'(i) < cache_cnt);
    for (int i = LANES - 1; i >= 0; i--) begin
      if (tk_in[i]) begin
        found = 1'b1;
        t_idx = CW'(i);
      end
    end
    keep = found ? t_idx + CW'(1) : cache_cnt;
    for (int i = 0; i < LANES; i++) mask[i] = (CW'(i) < keep);
  end

  assign seq_pc   = fetch_pc + PC_BITS'({keep, 2'b00});
  assign push_pkt = '{pc: fetch_pc, instr: fetched_data, lane_valid: mask, taken: tk_in & mask};

  assign redirect  = flush_valid | mispred_valid;
  assign redir_pc  = flush_valid ? flush_pc : mispred_pc;
  assign out_valid = !q_empty && !redirect;
  assign pop       = out_valid && out_ready;
  assign fetch_req = (pend != PEND_NONE) || redirect || !q_full || pop;
  assign accept    = cache_hit && fetch_req && !redirect && (pend == PEND_NONE);

  always_comb begin
    pend_nxt  = pend;
    saved_nxt = saved_pc;
    pc_nxt    = fetch_pc;
    count_inc = 1'b0;
    if (pend == PEND_NONE) begin
      if (redirect) begin
        if (cache_hit) begin
          pc_nxt    = redir_pc;
          count_inc = 1'b1;
        end else begin
          pend_nxt  = flush_valid ? PEND_HIGH : PEND_LOW;
          saved_nxt = redir_pc;
        end
      end else if (accept) begin
        pc_nxt = found ? pred_target : seq_pc;
      end
    end else if (cache_hit) begin
      // A fresh flush always wins; a fresh mispredict only beats a held mispredict.
      if (flush_valid)                             pc_nxt = flush_pc;
      else if (mispred_valid && pend == PEND_LOW)  pc_nxt = mispred_pc;
      else                                         pc_nxt = saved_pc;
      pend_nxt  = PEND_NONE;
      count_inc = 1'b1;
    end else if (flush_valid && pend == PEND_LOW) begin
      pend_nxt  = PEND_HIGH;
      saved_nxt = flush_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend           <= PEND_NONE;
      saved_pc       <= '0;
      fetch_pc       <= '0;
      perf_redirects <= '0;
    end else begin
      pend     <= pend_nxt;
      saved_pc <= saved_nxt;
      fetch_pc <= pc_nxt;
      if (count_inc && perf_redirects != '1) perf_redirects <= perf_redirects + 32'd1;
    end
  end

  fetch_pkt_queue #(.QDEPTH(QDEPTH), .T(pkt_t)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect),
    .push      (accept),
    .push_data (push_pkt),
    .pop       (pop),
    .head      (head_pkt),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign out_pc         = head_pkt.pc;
  assign out_instr      = head_pkt.instr;
  assign out_lane_valid = head_pkt.lane_valid;
  assign out_taken      = head_pkt.taken;

  logic [LANES-1:0] lv_plus;
  assign lv_plus = out_lane_valid + LANES'(1);

  a_lane_contig: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> (out_lane_valid != '0) && ((out_lane_valid & lv_plus) == '0));
  a_flush_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    flush_valid |-> !out_valid);
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    cache_hit |-> (cache_cnt >= CW'(1)) && (cache_cnt <= CW'(LANES)));

endmodule

// File: tb/tb_if_multi_fetch.sv
// tb/tb_if_multi_fetch.sv - directed table and sequence checks for if_multi_fetch
module tb_if_multi_fetch;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  fetch_pc;
  logic         fetch_req;
  logic         cache_hit;
  logic [2:0]   cache_cnt;
  logic [127:0] fetched_data;
  logic [3:0]   pred_taken;
  logic [31:0]  pred_target;
  logic         flush_valid;
  logic [31:0]  flush_pc;
  logic         mispred_valid;
  logic [31:0]  mispred_pc;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_pc;
  logic [127:0] out_instr;
  logic [3:0]   out_lane_valid;
  logic [3:0]   out_taken;
  logic [31:0]  perf_redirects;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_multi_fetch #(.PC_BITS(32), .INSTR_BITS(32), .LANES(4), .QDEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_pc       (fetch_pc),
    .fetch_req      (fetch_req),
    .cache_hit      (cache_hit),
    .cache_cnt      (cache_cnt),
    .fetched_data   (fetched_data),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .flush_valid    (flush_valid),
    .flush_pc       (flush_pc),
    .mispred_valid  (mispred_valid),
    .mispred_pc     (mispred_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_lane_valid (out_lane_valid),
    .out_taken      (out_taken),
    .perf_redirects (perf_redirects)
  );

  typedef struct {
    logic        hit;
    logic [2:0]  cnt;
    logic [3:0]  tk;
    logic [31:0] tgt;
    logic        ready;
    logic [31:0] e_fpc;
    logic        e_req;
    logic        e_ov;
    logic [31:0] e_opc;
    logic [3:0]  e_mask;
    logic [3:0]  e_taken;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [127:0] mkline(logic [31:0] pc);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = (pc + 32'(i*4)) ^ 32'hC0DE0000;
    return l;
  endfunction

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(logic hit, logic [31:0] pc, logic ready);
    cache_hit    = hit;
    cache_cnt    = 3'd4;
    pred_taken   = 4'b0000;
    pred_target  = 32'h0;
    out_ready    = ready;
    fetched_data = mkline(pc);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    flush_valid   = 1'b0;
    mispred_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1, 3'd4, 4'b0000, 32'h0,   1, 32'h000, 1, 0, 32'h000, 4'b0000, 4'b0000};
    vecs[1]  = '{1, 3'd4, 4'b0000, 32'h0,   1, 32'h010, 1, 1, 32'h000, 4'b1111, 4'b0000};
    vecs[2]  = '{1, 3'd4, 4'b0000, 32'h0,   1, 32'h020, 1, 1, 32'h010, 4'b1111, 4'b0000};
    vecs[3]  = '{1, 3'd2, 4'b0000, 32'h0,   1, 32'h030, 1, 1, 32'h020, 4'b1111, 4'b0000};
    vecs[4]  = '{1, 3'd2, 4'b0000, 32'h0,   1, 32'h038, 1, 1, 32'h030, 4'b0011, 4'b0000};
    vecs[5]  = '{1, 3'd4, 4'b0100, 32'h200, 1, 32'h040, 1, 1, 32'h038, 4'b0011, 4'b0000};
    vecs[6]  = '{1, 3'd4, 4'b0000, 32'h0,   1, 32'h200, 1, 1, 32'h040, 4'b0111, 4'b0100};
    vecs[7]  = '{1, 3'd2, 4'b1000, 32'h900, 1, 32'h210, 1, 1, 32'h200, 4'b1111, 4'b0000};
    vecs[8]  = '{1, 3'd4, 4'b0001, 32'h3fc, 1, 32'h218, 1, 1, 32'h210, 4'b0011, 4'b0000};
    vecs[9]  = '{0, 3'd4, 4'b0000, 32'h0,   1, 32'h3fc, 1, 1, 32'h218, 4'b0001, 4'b0001};
    vecs[10] = '{0, 3'd4, 4'b0000, 32'h0,   1, 32'h3fc, 1, 0, 32'h000, 4'b0000, 4'b0000};

    rst_n = 1'b0;
    flush_valid = 1'b0; flush_pc = '0; mispred_valid = 1'b0; mispred_pc = '0;
    drive(1'b0, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    chk("reset_fetch_pc", fetch_pc, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_perf", perf_redirects, 0);
    rst_n = 1'b1;

    // Streaming, line end, taken trim and taken-beyond-cnt rows
    for (int r = 0; r < 11; r++) begin
      cache_hit    = vecs[r].hit;
      cache_cnt    = vecs[r].cnt;
      pred_taken   = vecs[r].tk;
      pred_target  = vecs[r].tgt;
      out_ready    = vecs[r].ready;
      fetched_data = mkline(vecs[r].e_fpc);
      #1;
      chk($sformatf("v%0d_fetch_pc", r), fetch_pc, vecs[r].e_fpc);
      chk($sformatf("v%0d_fetch_req", r), fetch_req, vecs[r].e_req);
      chk($sformatf("v%0d_out_valid", r), out_valid, vecs[r].e_ov);
      if (vecs[r].e_ov) begin
        chk($sformatf("v%0d_out_pc", r), out_pc, vecs[r].e_opc);
        chk($sformatf("v%0d_lane_valid", r), out_lane_valid, vecs[r].e_mask);
        chk($sformatf("v%0d_taken", r), out_taken, vecs[r].e_taken);
        chk($sformatf("v%0d_instr", r), out_instr, mkline(vecs[r].e_opc));
      end
      next_cycle();
    end

    // Redirect on a hit, then fill the queue with decode stalled
    drive(1'b1, 32'h3fc, 1'b1);
    flush_valid = 1'b1; flush_pc = 32'h1000;
    #1 chk("flush_hit_out_valid", out_valid, 0);
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i < 4) ? 32'h1000 + 32'(i*16) : 32'h1040, 1'b0);
      #1;
      chk($sformatf("fill%0d_fetch_pc", i), fetch_pc, (i < 4) ? 32'h1000 + 32'(i*16) : 32'h1040);
      chk($sformatf("fill%0d_fetch_req", i), fetch_req, (i < 4) ? 1 : 0);
      next_cycle();
    end
    drive(1'b0, 32'h1040, 1'b0);
    #1;
    chk("full_fetch_req", fetch_req, 0);
    chk("full_fetch_pc", fetch_pc, 32'h1040);
    chk("full_head_pc", out_pc, 32'h1000);
    chk("full_perf", perf_redirects, 1);
    next_cycle();
    drive(1'b1, 32'h1040, 1'b1);
    #1 chk("full_pop_push_req", fetch_req, 1);
    chk("full_pop_push_head", out_pc, 32'h1000);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h1050, 1'b1);
      #1;
      chk($sformatf("drain%0d_out_valid", i), out_valid, (i < 4) ? 1 : 0);
      if (i < 4) begin
        chk($sformatf("drain%0d_out_pc", i), out_pc, 32'h1010 + 32'(i*16));
        chk($sformatf("drain%0d_instr", i), out_instr, mkline(32'h1010 + 32'(i*16)));
      end
      next_cycle();
    end
    chk("drain_fetch_pc", fetch_pc, 32'h1050);

    // Redirects held across a miss: mispredict, then flush overwrites
    drive(1'b0, 32'h1050, 1'b1);
    mispred_valid = 1'b1; mispred_pc = 32'h100;
    #1 chk("miss_mispred_out_valid", out_valid, 0);
    next_cycle();
    #1 chk("pend_fetch_req", fetch_req, 1);
    next_cycle();
    flush_valid = 1'b1; flush_pc = 32'h300;
    next_cycle();
    next_cycle();
    #1 chk("miss_fetch_pc_frozen", fetch_pc, 32'h1050);
    next_cycle();
    drive(1'b1, 32'h1050, 1'b1);
    next_cycle();
    drive(1'b0, 32'h300, 1'b1);
    #1;
    chk("held_fetch_pc", fetch_pc, 32'h300);
    chk("held_perf", perf_redirects, 2);
    chk("held_no_stale_pkt", out_valid, 0);
    next_cycle();

    // HIGH keeps its first pc; a mispredict on the hit cycle is ignored
    flush_valid = 1'b1; flush_pc = 32'h500;
    next_cycle();
    flush_valid = 1'b1; flush_pc = 32'h600;
    next_cycle();
    drive(1'b1, 32'h300, 1'b1);
    mispred_valid = 1'b1; mispred_pc = 32'h700;
    next_cycle();
    drive(1'b0, 32'h500, 1'b1);
    #1 chk("high_first_pc", fetch_pc, 32'h500);
    chk("high_perf", perf_redirects, 3);
    mispred_valid = 1'b1; mispred_pc = 32'h140;
    next_cycle();
    drive(1'b1, 32'h500, 1'b1);
    mispred_valid = 1'b1; mispred_pc = 32'h180;
    next_cycle();
    drive(1'b0, 32'h180, 1'b1);
    #1 chk("low_override_pc", fetch_pc, 32'h180);
    chk("low_override_perf", perf_redirects, 4);

    // Flush plus mispredict on a hit with three packets queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h180 + 32'(i*16), 1'b0);
      next_cycle();
    end
    drive(1'b1, 32'h1b0, 1'b1);
    #1 chk("three_queued_out_valid", out_valid, 1);
    flush_valid = 1'b1; flush_pc = 32'h800;
    mispred_valid = 1'b1; mispred_pc = 32'h900;
    #1 chk("both_redirect_out_valid", out_valid, 0);
    next_cycle();
    drive(1'b0, 32'h800, 1'b1);
    #1;
    chk("both_fetch_pc", fetch_pc, 32'h800);
    chk("both_queue_empty", out_valid, 0);
    chk("both_perf", perf_redirects, 5);
    next_cycle();

    // Reset pulsed during a full-queue stall
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i < 4) ? 32'h800 + 32'(i*16) : 32'h840, 1'b0);
      next_cycle();
    end
    #1 chk("stall_before_reset_req", fetch_req, 0);
    #2 rst_n = 1'b0;
    cache_hit = 1'b0;
    #1;
    chk("midreset_fetch_pc", fetch_pc, 0);
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_perf", perf_redirects, 0);
    chk("midreset_fetch_req", fetch_req, 1);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    #1 chk("after_reset_out_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
